ctl_data_merge_arb: RTL and testbench

- Packet-granular 2:1 arbiter placed after the packet filter.
- Merges the filter's data stream (AXIS with tready) and its control stream (AXIS without back-pressure) into one downstream AXIS pipeline.
- Control beats are buffered in an internal FIFO because the control source cannot be stalled. A control packet that cannot fit is dropped whole and counted.

---
 rtl/ctl_data_merge_arb_pkg.sv | 20 ++
 rtl/ctl_data_merge_arb_if.sv | 15 +
 rtl/ctl_data_merge_arb_ctl_fifo.sv | 48 ++++
 rtl/ctl_data_merge_arb.sv | 156 +++++++++++++++
 tb/tb_ctl_data_merge_arb.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ctl_data_merge_arb_pkg.sv
// Shared definitions for the filter back-end: protocol constants and the
// merge arbiter's state and grant encodings.
package ctl_data_merge_arb_pkg;

  localparam logic [15:0] ETH_TYPE_IPV4 = 16'h0800;
  localparam logic [7:0]  IP_PROTO_UDP  = 8'd17;
  localparam int          ETH_HDR_BYTES = 14;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SEND_DATA = 2'd1,
    SEND_CTL  = 2'd2
  } arb_state_e;

  typedef enum logic {
    GRANT_DATA = 1'b0,
    GRANT_CTL  = 1'b1
  } grant_e;

endpackage

// File: rtl/ctl_data_merge_arb_if.sv
// AXI4-Stream bundle used for the data, control and merged streams.
interface ctl_data_merge_arb_if #(
  parameter int DW = 512,
  parameter int UW = 128
);
  logic [DW-1:0]   tdata;
  logic [DW/8-1:0] tkeep;
  logic [UW-1:0]   tuser;
  logic            tvalid;
  logic            tlast;
  logic            tready;

  modport master (output tdata, tkeep, tuser, tvalid, tlast, input tready);
  modport slave  (input tdata, tkeep, tuser, tvalid, tlast, output tready);
endinterface

// File: rtl/ctl_data_merge_arb_ctl_fifo.sv
// Synchronous first-word-fall-through FIFO holding control beats; the head
// entry is always visible on rd_data while the FIFO is not empty.
module ctl_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     aresetn,
  input  logic                     wr_en,
  input  logic [W-1:0]             wr_data,
  input  logic                     rd_en,
  output logic [W-1:0]             rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   free
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          wr_ok;
  logic          rd_ok;

  // A write into a full FIFO is accepted only when a read frees the slot in the same cycle.
  assign wr_ok   = wr_en && (!full || rd_en);
  assign rd_ok   = rd_en && !empty;
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign free    = PW'(DEPTH) - (wr_ptr - rd_ptr);
  assign rd_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + PW'(1);
      if (rd_ok) rd_ptr <= rd_ptr + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/ctl_data_merge_arb.sv
// Packet-granular 2:1 merge of the filter data stream and its non-stallable
// control stream; control packets that cannot fit the FIFO are dropped whole.
module ctl_data_merge_arb
  import ctl_data_merge_arb_pkg::*;
#(
  parameter int C_S_AXIS_DATA_WIDTH  = 512,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int CTL_FIFO_DEPTH       = 16,
  parameter int CTL_MAX_PKT_BEATS    = 4
) (
  input  logic                 clk,
  input  logic                 aresetn,
  ctl_data_merge_arb_if.slave  s_axis,
  ctl_data_merge_arb_if.slave  c_s_axis,
  ctl_data_merge_arb_if.master m_axis,
  output logic [31:0]          ctl_drop_cnt,
  output logic [31:0]          ctl_pkt_cnt
);
  localparam int KW = C_S_AXIS_DATA_WIDTH / 8;
  localparam int FW = C_S_AXIS_DATA_WIDTH + KW + C_S_AXIS_TUSER_WIDTH + 1;
  localparam int AW = $clog2(CTL_FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam int BW = $clog2(CTL_MAX_PKT_BEATS + 1);

  arb_state_e    state_q, state_d;
  grant_e        last_grant_q, grant_d;

  logic [FW-1:0] fifo_wdata, fifo_rdata;
  logic          fifo_wr, fifo_rd, fifo_full, fifo_empty;
  logic [PW-1:0] fifo_free;
  logic [PW-1:0] cpkt;

  logic          c_in_pkt, c_wr_on;
  logic [BW-1:0] c_beats, c_beat_idx;
  logic          c_first, c_admit, c_take, c_force, c_last_w, c_trunc, c_reject;
  logic          cpkt_inc, cpkt_dec;
  logic          dreq, creq;

  // The control source cannot be stalled, so its ready is permanently asserted.
  assign c_s_axis.tready = 1'b1;

  ctl_fifo #(
    .W     (FW),
    .DEPTH (CTL_FIFO_DEPTH)
  ) u_ctl_fifo (
    .clk     (clk),
    .aresetn (aresetn),
    .wr_en   (fifo_wr),
    .wr_data (fifo_wdata),
    .rd_en   (fifo_rd),
    .rd_data (fifo_rdata),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .free    (fifo_free)
  );

  always_comb begin
    c_first    = !c_in_pkt;
    c_admit    = fifo_free >= PW'(CTL_MAX_PKT_BEATS);
    c_beat_idx = c_first ? BW'(1) : c_beats + BW'(1);
    c_take     = c_s_axis.tvalid && (c_first ? c_admit : c_wr_on);
    c_force    = (c_beat_idx == BW'(CTL_MAX_PKT_BEATS));
    c_last_w   = c_s_axis.tlast || c_force;
    c_trunc    = c_take && c_force && !c_s_axis.tlast;
    c_reject   = c_s_axis.tvalid && c_first && !c_admit;
    fifo_wr    = c_take && !fifo_full;
    fifo_wdata = {c_s_axis.tdata, c_s_axis.tkeep, c_s_axis.tuser, c_last_w};
    cpkt_inc   = fifo_wr && c_last_w;
    cpkt_dec   = fifo_rd && fifo_rdata[0];
  end

  // Write-side packet tracking: c_wr_on drops after the forced-tlast beat so the excess is discarded.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      c_in_pkt     <= 1'b0;
      c_wr_on      <= 1'b0;
      c_beats      <= '0;
      ctl_drop_cnt <= '0;
      cpkt         <= '0;
    end else begin
      if (c_s_axis.tvalid) begin
        c_in_pkt <= !c_s_axis.tlast;
        c_wr_on  <= c_take && !c_last_w;
        if (c_take) c_beats <= c_beat_idx;
      end
      if ((c_reject || c_trunc) && (ctl_drop_cnt != 32'hFFFF_FFFF))
        ctl_drop_cnt <= ctl_drop_cnt + 32'd1;
      case ({cpkt_inc, cpkt_dec})
        2'b10:   cpkt <= cpkt + PW'(1);
        2'b01:   cpkt <= cpkt - PW'(1);
        default: cpkt <= cpkt;
      endcase
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q      <= IDLE;
      last_grant_q <= GRANT_CTL;
      ctl_pkt_cnt  <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= grant_d;
      if (cpkt_dec) ctl_pkt_cnt <= ctl_pkt_cnt + 32'd1;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = last_grant_q;
    dreq    = s_axis.tvalid;
    creq    = (cpkt != '0);
    case (state_q)
      IDLE: begin
        if (dreq && creq)
          grant_d = (last_grant_q == GRANT_CTL) ? GRANT_DATA : GRANT_CTL;
        else if (dreq)
          grant_d = GRANT_DATA;
        else if (creq)
          grant_d = GRANT_CTL;
        if (dreq || creq)
          state_d = (grant_d == GRANT_DATA) ? SEND_DATA : SEND_CTL;
      end
      SEND_DATA: if (s_axis.tvalid && m_axis.tready && s_axis.tlast) state_d = IDLE;
      SEND_CTL:  if (cpkt_dec) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_comb begin
    m_axis.tdata  = '0;
    m_axis.tkeep  = '0;
    m_axis.tuser  = '0;
    m_axis.tlast  = 1'b0;
    m_axis.tvalid = 1'b0;
    s_axis.tready = 1'b0;
    fifo_rd       = 1'b0;
    case (state_q)
      SEND_DATA: begin
        m_axis.tdata  = s_axis.tdata;
        m_axis.tkeep  = s_axis.tkeep;
        m_axis.tuser  = s_axis.tuser;
        m_axis.tlast  = s_axis.tlast;
        m_axis.tvalid = s_axis.tvalid;
        s_axis.tready = m_axis.tready;
      end
      SEND_CTL: begin
        {m_axis.tdata, m_axis.tkeep, m_axis.tuser, m_axis.tlast} = fifo_rdata;
        m_axis.tvalid = !fifo_empty;
        fifo_rd       = !fifo_empty && m_axis.tready;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ctl_data_merge_arb.sv
// Scoreboard bench for ctl_data_merge_arb: beats are queued per source when
// driven and compared in order as they leave the merged output.
module tb_ctl_data_merge_arb;
  localparam int DW = 512;
  localparam int UW = 128;
  localparam int KW = DW / 8;

  logic clk = 1'b0;
  logic aresetn = 1'b0;
  int   cyc = 0;

  ctl_data_merge_arb_if #(.DW(DW), .UW(UW)) s_if ();
  ctl_data_merge_arb_if #(.DW(DW), .UW(UW)) c_if ();
  ctl_data_merge_arb_if #(.DW(DW), .UW(UW)) m_if ();
  logic [31:0] ctl_drop_cnt, ctl_pkt_cnt;

  ctl_data_merge_arb dut (
    .clk          (clk),
    .aresetn      (aresetn),
    .s_axis       (s_if),
    .c_s_axis     (c_if),
    .m_axis       (m_if),
    .ctl_drop_cnt (ctl_drop_cnt),
    .ctl_pkt_cnt  (ctl_pkt_cnt)
  );

  always #5 clk = ~clk;
  initial forever begin @(posedge clk); cyc++; end

  typedef struct {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic [UW-1:0] user;
    logic          last;
  } beat_t;

  beat_t q_d[$];
  beat_t q_c[$];
  int    hs_cyc[$];
  logic  ord[$];
  int    n_chk = 0;
  int    n_fail = 0;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic beat_t make_beat(input logic src, input int id, input int b, input logic last);
    beat_t bt;
    for (int i = 0; i < DW / 32; i++) bt.data[i*32 +: 32] = $urandom;
    bt.data[DW-1 -: 32] = {src, 7'd0, 8'(id), 8'(b), 8'hA5};
    bt.keep = {$urandom, $urandom};
    bt.user = {$urandom, $urandom, $urandom, $urandom};
    bt.last = last;
    return bt;
  endfunction

  // Output monitor: stall stability, then scoreboard compare per source.
  initial begin
    beat_t prev, e;
    logic  prev_stall;
    logic  src;
    prev_stall = 1'b0;
    forever begin
      @(negedge clk);
      if (!aresetn) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          chk("hold_valid", m_if.tvalid, 1'b1);
          chk("hold_data", m_if.tdata, prev.data);
          chk("hold_last", m_if.tlast, prev.last);
        end
        if (m_if.tvalid && m_if.tready) begin
          src = m_if.tdata[DW-1];
          hs_cyc.push_back(cyc);
          if (m_if.tlast) ord.push_back(src);
          if (src) begin
            chk("sb_ctl_avail", q_c.size() > 0, 1'b1);
            if (q_c.size() > 0) begin
              e = q_c.pop_front();
              chk("ctl_data", m_if.tdata, e.data);
              chk("ctl_keep", m_if.tkeep, e.keep);
              chk("ctl_user", m_if.tuser, e.user);
              chk("ctl_last", m_if.tlast, e.last);
            end
          end else begin
            chk("sb_data_avail", q_d.size() > 0, 1'b1);
            if (q_d.size() > 0) begin
              e = q_d.pop_front();
              chk("data_data", m_if.tdata, e.data);
              chk("data_keep", m_if.tkeep, e.keep);
              chk("data_user", m_if.tuser, e.user);
              chk("data_last", m_if.tlast, e.last);
            end
          end
        end
        prev_stall = m_if.tvalid && !m_if.tready;
        prev.data  = m_if.tdata;
        prev.last  = m_if.tlast;
      end
    end
  end

  task automatic drive_data_beat(input beat_t bt);
    int n;
    n = 0;
    q_d.push_back(bt);
    s_if.tdata  = bt.data;
    s_if.tkeep  = bt.keep;
    s_if.tuser  = bt.user;
    s_if.tlast  = bt.last;
    s_if.tvalid = 1'b1;
    do begin @(negedge clk); n++; end while (!s_if.tready && n < 500);
    chk("s_ready_wait", s_if.tready, 1'b1);
    @(posedge clk); #1;
    s_if.tvalid = 1'b0;
  endtask

  task automatic send_data(input int nb, input int id);
    for (int b = 0; b < nb; b++) drive_data_beat(make_beat(1'b0, id, b, b == nb - 1));
  endtask

  // exp_n beats are expected out, the last of them carrying tlast.
  task automatic send_ctl(input int nb, input int id, input int exp_n, input bit term);
    beat_t bt, e;
    for (int b = 0; b < nb; b++) begin
      bt = make_beat(1'b1, id, b, term && (b == nb - 1));
      c_if.tdata  = bt.data;
      c_if.tkeep  = bt.keep;
      c_if.tuser  = bt.user;
      c_if.tlast  = bt.last;
      c_if.tvalid = 1'b1;
      if (b < exp_n) begin
        e = bt;
        e.last = bt.last || (b == exp_n - 1);
        q_c.push_back(e);
      end
      @(posedge clk); #1;
    end
    c_if.tvalid = 1'b0;
    c_if.tlast  = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while ((q_d.size() + q_c.size()) != 0 && n < 1000) begin @(posedge clk); n++; end
    repeat (2) @(posedge clk);
    #1;
    chk(tag, q_d.size() + q_c.size(), 0);
  endtask

  task automatic pulse_reset();
    s_if.tvalid = 1'b0;
    c_if.tvalid = 1'b0;
    aresetn = 1'b0;
    #1;
    chk("rst_pkt_cnt", ctl_pkt_cnt, 0);
    chk("rst_drop_cnt", ctl_drop_cnt, 0);
    @(negedge clk) aresetn = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic exp_ord [4];
    exp_ord = '{1'b0, 1'b1, 1'b0, 1'b1};
    s_if.tdata = '0; s_if.tkeep = '0; s_if.tuser = '0; s_if.tvalid = 1'b0; s_if.tlast = 1'b0;
    c_if.tdata = '0; c_if.tkeep = '0; c_if.tuser = '0; c_if.tvalid = 1'b0; c_if.tlast = 1'b0;
    m_if.tready = 1'b1;

    #12;
    chk("reset_m_tvalid", m_if.tvalid, 1'b0);
    chk("reset_m_tdata", m_if.tdata, '0);
    chk("reset_m_tkeep", m_if.tkeep, '0);
    chk("reset_m_tuser", m_if.tuser, '0);
    chk("reset_m_tlast", m_if.tlast, 1'b0);
    chk("reset_s_tready", s_if.tready, 1'b0);
    chk("reset_drop_cnt", ctl_drop_cnt, 0);
    chk("reset_pkt_cnt", ctl_pkt_cnt, 0);
    @(negedge clk) aresetn = 1'b1;
    @(posedge clk); #1;

    // Data only: one bubble cycle between packets.
    hs_cyc.delete();
    for (int p = 0; p < 3; p++) send_data(2, p);
    wait_drain("data_only_drain");
    chk("data_only_beats", hs_cyc.size(), 6);
    if (hs_cyc.size() >= 6)
      for (int i = 1; i < 6; i++) chk("data_only_gap", hs_cyc[i] - hs_cyc[i-1], (i % 2) ? 1 : 2);
    chk("data_only_pkt_cnt", ctl_pkt_cnt, 0);

    // Control only: three contiguous beats.
    hs_cyc.delete();
    send_ctl(3, 10, 3, 1'b1);
    wait_drain("ctl_only_drain");
    chk("ctl_only_beats", hs_cyc.size(), 3);
    if (hs_cyc.size() >= 3)
      for (int i = 1; i < 3; i++) chk("ctl_only_gap", hs_cyc[i] - hs_cyc[i-1], 1);
    chk("ctl_only_pkt_cnt", ctl_pkt_cnt, 1);

    // Contention straight after reset: data first, then alternate.
    pulse_reset();
    ord.delete();
    fork
      begin
        send_ctl(2, 20, 2, 1'b1);
        send_ctl(2, 21, 2, 1'b1);
      end
      begin
        repeat (2) @(posedge clk);
        #1;
        send_data(2, 30);
        send_data(2, 31);
      end
    join
    wait_drain("contention_drain");
    chk("contention_pkts", ord.size(), 4);
    if (ord.size() >= 4)
      for (int i = 0; i < 4; i++) chk("contention_order", ord[i], exp_ord[i]);
    chk("contention_pkt_cnt", ctl_pkt_cnt, 2);

    // Overflow: fifth packet finds no room.
    m_if.tready = 1'b0;
    for (int k = 0; k < 5; k++) send_ctl(4, 40 + k, (k < 4) ? 4 : 0, 1'b1);
    chk("overflow_drop_cnt", ctl_drop_cnt, 1);
    chk("overflow_pkt_cnt_stalled", ctl_pkt_cnt, 2);
    m_if.tready = 1'b1;
    wait_drain("overflow_drain");
    chk("overflow_pkt_cnt", ctl_pkt_cnt, 6);

    // Truncation of a 6-beat control packet.
    send_ctl(6, 50, 4, 1'b1);
    wait_drain("trunc_drain");
    chk("trunc_drop_cnt", ctl_drop_cnt, 2);
    chk("trunc_pkt_cnt", ctl_pkt_cnt, 7);

    // Back-pressure toggling every cycle.
    begin
      bit tog_en;
      tog_en = 1'b1;
      fork
        begin send_data(4, 60); tog_en = 1'b0; end
        while (tog_en) begin @(posedge clk); #1; m_if.tready = !m_if.tready; end
      join
    end
    m_if.tready = 1'b1;
    wait_drain("bp_drain");
    chk("bp_pkt_cnt", ctl_pkt_cnt, 7);

    // Reset in the middle of a data packet and a partial control packet.
    send_ctl(2, 70, 0, 1'b0);
    drive_data_beat(make_beat(1'b0, 71, 0, 1'b0));
    drive_data_beat(make_beat(1'b0, 71, 1, 1'b0));
    begin
      beat_t bt;
      bt = make_beat(1'b0, 71, 2, 1'b0);
      s_if.tdata = bt.data; s_if.tkeep = bt.keep; s_if.tuser = bt.user; s_if.tlast = 1'b0;
      s_if.tvalid = 1'b1;
      #1;
      chk("pre_reset_m_tvalid", m_if.tvalid, 1'b1);
    end
    aresetn = 1'b0;
    #1;
    chk("midrst_m_tvalid", m_if.tvalid, 1'b0);
    chk("midrst_m_tdata", m_if.tdata, '0);
    chk("midrst_m_tlast", m_if.tlast, 1'b0);
    chk("midrst_s_tready", s_if.tready, 1'b0);
    chk("midrst_drop_cnt", ctl_drop_cnt, 0);
    chk("midrst_pkt_cnt", ctl_pkt_cnt, 0);
    s_if.tvalid = 1'b0;
    q_d.delete();
    q_c.delete();
    @(negedge clk) aresetn = 1'b1;
    @(posedge clk); #1;
    send_ctl(2, 72, 2, 1'b1);
    wait_drain("post_reset_drain");
    chk("post_reset_pkt_cnt", ctl_pkt_cnt, 1);
    chk("post_reset_drop_cnt", ctl_drop_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
